// File: rtl/alu_bitserial_ctrl.sv
// Bit-serial ALU sequencer: feeds one external 1-bit ALU slice LSB first over
// WIDTH cycles, assembles the result word and handles shifts internally.
module alu_bitserial_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  input  logic             req_cin_i,
  input  logic [3:0]       req_sel_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] resp_f_o,
  output logic             resp_cout_o,
  output logic             busy_o,
  output logic             slice_a_o,
  output logic             slice_b_o,
  output logic             slice_cin_o,
  output logic [3:0]       slice_sel_o,
  input  logic             slice_f_i,
  input  logic             slice_cout_i
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, f_q;
  logic [WIDTH-1:0] res_next, shr_w, shl_w;
  logic [3:0]       sel_q;
  logic [CW-1:0]    cnt_q;
  logic             cin_q, carry_q, cout_q;
  logic             res_bit, cout_next;
  logic             run, accept, last;

  assign run    = (state_q == RUN);
  assign accept = (state_q == IDLE) && req_valid_i;
  assign last   = run && (cnt_q == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid_i)  state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shifted copies of A turn the shr/shl boundary bits into plain zero fill.
  assign shr_w = {1'b0, a_q[WIDTH-1:1]};
  assign shl_w = {a_q[WIDTH-2:0], 1'b0};

  always_comb begin
    res_bit = slice_f_i;
    if (sel_q[3]) res_bit = sel_q[2] ? shl_w[cnt_q] : shr_w[cnt_q];
    res_next        = res_q;
    res_next[cnt_q] = res_bit;
  end

  always_comb begin
    cout_next = 1'b0;
    unique case (sel_q[3:2])
      2'b00:   cout_next = slice_cout_i;
      2'b01:   cout_next = 1'b0;
      2'b10:   cout_next = a_q[0];
      2'b11:   cout_next = a_q[WIDTH-1];
      default: cout_next = 1'b0;
    endcase
  end

  // NOTE: reset clears the whole datapath, not just control, because the
  // response word and latched select are visible on the ports after reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      f_q     <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= req_a_i;
        b_q   <= req_b_i;
        cin_q <= req_cin_i;
        sel_q <= req_sel_i;
        cnt_q <= '0;
      end
      if (run) begin
        res_q <= res_next;
        if (!sel_q[3]) carry_q <= slice_cout_i;
        if (!last)     cnt_q   <= cnt_q + CW'(1);
      end
      // The visible response only updates on entry to DONE.
      if (last) begin
        f_q    <= res_next;
        cout_q <= cout_next;
      end
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign resp_f_o     = f_q;
  assign resp_cout_o  = cout_q;

  assign slice_a_o   = run & a_q[cnt_q];
  assign slice_b_o   = run & b_q[cnt_q];
  assign slice_cin_o = run & ((cnt_q == '0) ? cin_q : carry_q);
  assign slice_sel_o = sel_q;

endmodule

// File: tb/tb_alu_bitserial_ctrl.sv
// Directed checks on an 8-bit instance plus a randomised regression on a
// 32-bit instance, each driving a full-adder/AND slice stub.
module tb_alu_bitserial_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- 8-bit instance ----------------
  logic       d_req_valid, d_req_ready, d_req_cin, d_resp_valid, d_resp_ready;
  logic [7:0] d_req_a, d_req_b, d_resp_f;
  logic [3:0] d_req_sel, d_slice_sel;
  logic       d_resp_cout, d_busy, d_slice_a, d_slice_b, d_slice_cin;
  logic       d_slice_f, d_slice_cout;

  always_comb begin
    d_slice_f    = (d_slice_sel[3:2] == 2'b00) ? (d_slice_a ^ d_slice_b ^ d_slice_cin)
                                               : (d_slice_a & d_slice_b);
    d_slice_cout = (d_slice_a & d_slice_b) | (d_slice_a & d_slice_cin) | (d_slice_b & d_slice_cin);
  end

  alu_bitserial_ctrl #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(d_req_valid), .req_ready_o(d_req_ready),
    .req_a_i(d_req_a), .req_b_i(d_req_b), .req_cin_i(d_req_cin), .req_sel_i(d_req_sel),
    .resp_valid_o(d_resp_valid), .resp_ready_i(d_resp_ready),
    .resp_f_o(d_resp_f), .resp_cout_o(d_resp_cout), .busy_o(d_busy),
    .slice_a_o(d_slice_a), .slice_b_o(d_slice_b), .slice_cin_o(d_slice_cin),
    .slice_sel_o(d_slice_sel), .slice_f_i(d_slice_f), .slice_cout_i(d_slice_cout)
  );

  // ---------------- 32-bit instance ----------------
  logic        r_req_valid, r_req_ready, r_req_cin, r_resp_valid, r_resp_ready;
  logic [31:0] r_req_a, r_req_b, r_resp_f;
  logic [3:0]  r_req_sel, r_slice_sel;
  logic        r_resp_cout, r_busy, r_slice_a, r_slice_b, r_slice_cin;
  logic        r_slice_f, r_slice_cout;

  always_comb begin
    r_slice_f    = (r_slice_sel[3:2] == 2'b00) ? (r_slice_a ^ r_slice_b ^ r_slice_cin)
                                               : (r_slice_a & r_slice_b);
    r_slice_cout = (r_slice_a & r_slice_b) | (r_slice_a & r_slice_cin) | (r_slice_b & r_slice_cin);
  end

  alu_bitserial_ctrl #(.WIDTH(32)) dut32 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(r_req_valid), .req_ready_o(r_req_ready),
    .req_a_i(r_req_a), .req_b_i(r_req_b), .req_cin_i(r_req_cin), .req_sel_i(r_req_sel),
    .resp_valid_o(r_resp_valid), .resp_ready_i(r_resp_ready),
    .resp_f_o(r_resp_f), .resp_cout_o(r_resp_cout), .busy_o(r_busy),
    .slice_a_o(r_slice_a), .slice_b_o(r_slice_b), .slice_cin_o(r_slice_cin),
    .slice_sel_o(r_slice_sel), .slice_f_i(r_slice_f), .slice_cout_i(r_slice_cout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit operation with resp_ready held high; checks operand bits fed to
  // the slice, carry chaining (arith only), latency and the result.
  task automatic run_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [3:0] sel,
                         input logic [7:0] exp_f, input logic exp_cout);
    int   edges;
    int   k;
    logic prev_cout;
    d_req_a = a; d_req_b = b; d_req_cin = cin; d_req_sel = sel;
    d_req_valid = 1'b1; d_resp_ready = 1'b1;
    check({tag, "_ready"}, 64'(d_req_ready), 64'd1);
    tick();
    d_req_valid = 1'b0;
    edges = 1;
    prev_cout = 1'b0;
    while (!d_resp_valid && edges < 40) begin
      k = edges - 1;
      if (k < 8) begin
        check({tag, "_sa"}, 64'(d_slice_a), 64'(a[k]));
        check({tag, "_sb"}, 64'(d_slice_b), 64'(b[k]));
      end
      if (sel[3:2] == 2'b00) begin
        check({tag, "_chain"}, 64'(d_slice_cin), 64'((k == 0) ? cin : prev_cout));
        prev_cout = d_slice_cout;
      end
      tick();
      edges++;
    end
    // Edges counted from the accept edge inclusive.
    check({tag, "_latency"}, 64'(edges), 64'd9);
    check({tag, "_f"}, 64'(d_resp_f), 64'(exp_f));
    check({tag, "_cout"}, 64'(d_resp_cout), 64'(exp_cout));
    tick();
    check({tag, "_idle_valid"}, 64'(d_resp_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(d_req_ready), 64'd1);
    check({tag, "_retain_f"}, 64'(d_resp_f), 64'(exp_f));
  endtask

  initial begin
    int   cyc;
    logic seen;

    rst_n = 1'b0;
    d_req_valid = 0; d_req_a = 0; d_req_b = 0; d_req_cin = 0; d_req_sel = 0; d_resp_ready = 0;
    r_req_valid = 0; r_req_a = 0; r_req_b = 0; r_req_cin = 0; r_req_sel = 0; r_resp_ready = 0;
    tick();
    tick();
    rst_n = 1'b1;

    check("rst_ready",  64'(d_req_ready),  64'd1);
    check("rst_valid",  64'(d_resp_valid), 64'd0);
    check("rst_f",      64'(d_resp_f),     64'd0);
    check("rst_cout",   64'(d_resp_cout),  64'd0);
    check("rst_busy",   64'(d_busy),       64'd0);
    check("rst_slice",  64'({d_slice_a, d_slice_b, d_slice_cin, d_slice_sel}), 64'd0);

    run_op8("add", 8'hFF, 8'h01, 1'b0, 4'b0000, 8'h00, 1'b1);
    run_op8("add_cin", 8'h12, 8'h34, 1'b1, 4'b0000, 8'h47, 1'b0);
    run_op8("logic", 8'hA5, 8'h3C, 1'b0, 4'b0100, 8'h24, 1'b0);
    run_op8("shr", 8'h81, 8'h00, 1'b0, 4'b1000, 8'h40, 1'b1);
    run_op8("shl", 8'h81, 8'h00, 1'b0, 4'b1100, 8'h02, 1'b1);

    // Backpressure: response held while a new request waits.
    d_req_a = 8'h12; d_req_b = 8'h34; d_req_cin = 0; d_req_sel = 4'b0000;
    d_req_valid = 1'b1; d_resp_ready = 1'b0;
    tick();
    d_req_a = 8'h0F; d_req_b = 8'hF3; d_req_sel = 4'b0100;
    cyc = 0;
    while (!d_resp_valid && cyc < 40) begin tick(); cyc++; end
    check("bp_reach_done", 64'(d_resp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_f",     64'(d_resp_f),     64'h46);
      check("bp_cout",  64'(d_resp_cout),  64'd0);
      check("bp_valid", 64'(d_resp_valid), 64'd1);
      check("bp_ready", 64'(d_req_ready),  64'd0);
      tick();
    end
    d_resp_ready = 1'b1;
    tick();
    check("bp_hs_ready", 64'(d_req_ready), 64'd1);
    check("bp_hs_busy",  64'(d_busy),      64'd0);
    check("bp_hs_f",     64'(d_resp_f),    64'h46);
    tick();
    check("bp_accept_busy", 64'(d_busy), 64'd1);
    d_req_valid = 1'b0;
    cyc = 0;
    while (!d_resp_valid && cyc < 40) begin tick(); cyc++; end
    check("bp_second_f",    64'(d_resp_f),    64'h03);
    check("bp_second_cout", 64'(d_resp_cout), 64'd0);
    tick();

    // Reset in the middle of an operation.
    d_req_a = 8'h5A; d_req_b = 8'h33; d_req_cin = 0; d_req_sel = 4'b0001;
    d_req_valid = 1'b1; d_resp_ready = 1'b1;
    tick();
    d_req_valid = 1'b0;
    tick(); tick(); tick();
    check("mid_run_bit3", 64'(d_slice_a), 64'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_ready", 64'(d_req_ready),  64'd1);
    check("mid_rst_valid", 64'(d_resp_valid), 64'd0);
    check("mid_rst_busy",  64'(d_busy),       64'd0);
    check("mid_rst_f",     64'(d_resp_f),     64'd0);
    check("mid_rst_slice", 64'({d_slice_a, d_slice_b, d_slice_cin, d_slice_sel}), 64'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (d_resp_valid || d_busy) seen = 1'b1;
      tick();
    end
    check("mid_rst_no_resp", 64'(seen), 64'd0);

    // Random regression on the 32-bit instance.
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] a, b;
      logic        cin, got, done, rr;
      logic [3:0]  sel;
      logic [32:0] exp;
      int          viol;
      a = $urandom(); b = $urandom(); cin = 1'($urandom_range(0, 1));
      sel = 4'($urandom_range(0, 15));
      unique case (sel[3:2])
        2'b00:   exp = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        2'b01:   exp = {1'b0, a & b};
        2'b10:   exp = {a[0], 1'b0, a[31:1]};
        default: exp = {a[31], a[30:0], 1'b0};
      endcase
      r_req_a = a; r_req_b = b; r_req_cin = cin; r_req_sel = sel; r_req_valid = 1'b1;
      viol = 0;
      if (r_slice_a | r_slice_b | r_slice_cin) viol++;
      tick();
      r_req_valid = 1'b0;
      got = 1'b0; done = 1'b0; cyc = 0;
      while (!done && cyc < 200) begin
        if (!(r_busy && !r_resp_valid) && (r_slice_a | r_slice_b | r_slice_cin)) viol++;
        if (r_resp_valid && !got) begin
          check("rnd_result", 64'({r_resp_cout, r_resp_f}), 64'(exp));
          got = 1'b1;
        end
        rr = 1'($urandom_range(0, 1));
        r_resp_ready = rr;
        tick();
        cyc++;
        if (got && rr) done = 1'b1;
      end
      check("rnd_complete", 64'(done), 64'd1);
      check("rnd_slice_idle", 64'(viol), 64'd0);
      if (!done) break;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
